// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_arbiter
// Description : Shares one combinational ALU between two issue slots.
//               Round-robin grant of at most one requester per cycle, a
//               zero-when-idle operand mux toward the ALU, and a one-entry
//               output register (result, tag, source id) with valid/ready
//               backpressure toward writeback. flush kills the held result
//               and suppresses grants for the cycle.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               flush                 - pipeline redirect
//               in{0,1}_valid/ready   - requester handshakes
//               in{0,1}_aluop/src1/src2/tag - requester payloads
//               alu_aluop/reg1/reg2   - operands driven to the shared ALU
//               alu_result            - combinational ALU result
//               out_valid/ready       - writeback handshake
//               out_result/tag/src    - registered result, tag, requester id
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,

    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [7:0]       in0_aluop,
    input  logic [31:0]      in0_src1,
    input  logic [31:0]      in0_src2,
    input  logic [TAG_W-1:0] in0_tag,

    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [7:0]       in1_aluop,
    input  logic [31:0]      in1_src1,
    input  logic [31:0]      in1_src2,
    input  logic [TAG_W-1:0] in1_tag,

    output logic [7:0]       alu_aluop,
    output logic [31:0]      alu_reg1,
    output logic [31:0]      alu_reg2,
    input  logic [31:0]      alu_result,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_src;
    logic             r_rr_ptr;

    logic             w_can_accept;
    logic             w_gnt0;
    logic             w_gnt1;

    // rst gates acceptance so requesters never see ready while in reset.
    assign w_can_accept = !rst && !flush && (!r_out_valid || out_ready);

    // A lone requester wins regardless of the pointer; on a tie the pointer
    // decides. The two terms are mutually exclusive by construction.
    assign w_gnt0 = w_can_accept && in0_valid && (!in1_valid || (r_rr_ptr == 1'b0));
    assign w_gnt1 = w_can_accept && in1_valid && (!in0_valid || (r_rr_ptr == 1'b1));

    assign in0_ready = w_gnt0;
    assign in1_ready = w_gnt1;

    // Operands are forced to zero without a grant so the ALU sits idle.
    always_comb begin
        alu_aluop = 8'h00;
        alu_reg1  = 32'h0;
        alu_reg2  = 32'h0;
        if (w_gnt0) begin
            alu_aluop = in0_aluop;
            alu_reg1  = in0_src1;
            alu_reg2  = in0_src2;
        end else if (w_gnt1) begin
            alu_aluop = in1_aluop;
            alu_reg1  = in1_src1;
            alu_reg2  = in1_src2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 32'h0;
            r_out_tag    <= '0;
            r_out_src    <= 1'b0;
            r_rr_ptr     <= 1'b0;
        end else if (flush) begin
            // Held result is discarded; pointer and data fields hold.
            r_out_valid <= 1'b0;
        end else if (w_gnt0 || w_gnt1) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_tag    <= w_gnt1 ? in1_tag : in0_tag;
            r_out_src    <= w_gnt1;
            // Next tie goes to the requester that was not just served.
            r_rr_ptr     <= ~w_gnt1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign out_src    = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_arbiter
// Description : Self-checking bench for alu_issue_arbiter. A small ALU model
//               answers alu_* combinationally. The stimulus process pushes the
//               hand-computed result of every expected grant into a
//               scoreboard queue; a monitor pops and compares whenever the
//               DUT hands a result to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

    localparam int TAG_W = 6;

    // Opcode encodings used by the bench-side ALU model.
    localparam logic [7:0] ALU_ADDW = 8'h20;
    localparam logic [7:0] ALU_SUBW = 8'h22;
    localparam logic [7:0] ALU_OR   = 8'h25;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in0_valid, in1_valid;
    logic             in0_ready, in1_ready;
    logic [7:0]       in0_aluop, in1_aluop;
    logic [31:0]      in0_src1, in0_src2, in1_src1, in1_src2;
    logic [TAG_W-1:0] in0_tag, in1_tag;
    logic [7:0]       alu_aluop;
    logic [31:0]      alu_reg1, alu_reg2;
    logic [31:0]      alu_result;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             out_src;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             src;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in0_aluop  (in0_aluop),
        .in0_src1   (in0_src1),
        .in0_src2   (in0_src2),
        .in0_tag    (in0_tag),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in1_aluop  (in1_aluop),
        .in1_src1   (in1_src1),
        .in1_src2   (in1_src2),
        .in1_tag    (in1_tag),
        .alu_aluop  (alu_aluop),
        .alu_reg1   (alu_reg1),
        .alu_reg2   (alu_reg2),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_src    (out_src)
    );

    // Combinational ALU model; unknown opcodes (including 0) give 0.
    always_comb begin
        case (alu_aluop)
            ALU_ADDW: alu_result = alu_reg1 + alu_reg2;
            ALU_SUBW: alu_result = alu_reg1 - alu_reg2;
            ALU_OR:   alu_result = alu_reg1 | alu_reg2;
            default:  alu_result = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every handshake on the writeback side retires one entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got result %h with empty scoreboard", out_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", out_result, e.result);
                chk("out_tag", {26'h0, out_tag}, {26'h0, e.tag});
                chk("out_src", {31'h0, out_src}, {31'h0, e.src});
            end
        end
    end

    // One cycle of stimulus: inputs are applied just after a rising edge,
    // readies/ALU port are checked at the falling edge, and the expected
    // result of the predicted grant is queued.
    task automatic cyc(input logic v0, input logic v1, input logic fl, input logic rs,
                       input logic ordy, input logic e0, input logic e1,
                       input logic [31:0] eres, input logic [TAG_W-1:0] etag);
        in0_valid = v0;
        in1_valid = v1;
        flush     = fl;
        rst       = rs;
        out_ready = ordy;
        if (e0 || e1) begin
            exp_t e;
            e.result = eres;
            e.tag    = etag;
            e.src    = e1;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("in0_ready", {31'h0, in0_ready}, {31'h0, e0});
        chk("in1_ready", {31'h0, in1_ready}, {31'h0, e1});
        if (!(e0 || e1)) begin
            chk("alu_aluop_idle", {24'h0, alu_aluop}, 32'h0);
            chk("alu_reg1_idle", alu_reg1, 32'h0);
            chk("alu_reg2_idle", alu_reg2, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_aluop = ALU_ADDW; in0_src1 = 32'd5; in0_src2 = 32'd7; in0_tag = 6'd3;
        in1_aluop = ALU_OR; in1_src1 = 32'hF0; in1_src2 = 32'h0F; in1_tag = 6'd20;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_result", out_result, 32'h0);
        chk("reset_out_tag", {26'h0, out_tag}, 32'h0);
        chk("reset_out_src", {31'h0, out_src}, 32'h0);
        @(posedge clk);
        #1;

        // Lone requester 0: ADDW 5+7 = 12, tag 3; rr_ptr moves to 1.
        cyc(1, 0, 0, 0, 0, 1, 0, 32'd12, 6'd3);
        chk("lone_out_valid", {31'h0, out_valid}, 32'h1);

        // Tie traffic: in0 SUBW 3-5, in1 OR F0|0F. Pointer is 1, so 1,0,1,0.
        in0_aluop = ALU_SUBW; in0_src1 = 32'd3; in0_src2 = 32'd5; in0_tag = 6'd10;
        cyc(1, 1, 0, 0, 1, 0, 1, 32'h000000FF, 6'd20);
        cyc(1, 1, 0, 0, 1, 1, 0, 32'hFFFFFFFE, 6'd10);
        cyc(1, 1, 0, 0, 1, 0, 1, 32'h000000FF, 6'd20);
        cyc(1, 1, 0, 0, 1, 1, 0, 32'hFFFFFFFE, 6'd10);

        // Backpressure: in1 waits while the SUBW result is stalled.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 6'd0);
            chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_out_result", out_result, 32'hFFFFFFFE);
        end
        // Drain and accept in1 in the same cycle.
        cyc(0, 1, 0, 0, 1, 0, 1, 32'h000000FF, 6'd20);
        chk("drain_accept_valid", {31'h0, out_valid}, 32'h1);

        // Flush while stalled: held OR result is discarded, in0 not granted.
        void'(sb.pop_back());
        cyc(1, 0, 1, 0, 0, 0, 0, 32'h0, 6'd0);
        chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
        // Flush released: in0 granted into the empty register.
        cyc(1, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFE, 6'd10);

        // Idle: result drains after one ready cycle; pointer now 1.
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0, 6'd0);
        chk("idle_out_valid", {31'h0, out_valid}, 32'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0, 6'd0);
        // Tie after idle: pointer unchanged at 1, so in1 wins.
        cyc(1, 1, 0, 0, 0, 0, 1, 32'h000000FF, 6'd20);

        // Reset mid-stream with both valid and a held result.
        sb.delete();
        cyc(1, 1, 0, 1, 0, 0, 0, 32'h0, 6'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_tag", {26'h0, out_tag}, 32'h0);
        chk("rst_out_src", {31'h0, out_src}, 32'h0);
        // After release the pointer is back at 0: in0 wins the tie.
        cyc(1, 1, 0, 0, 0, 1, 0, 32'hFFFFFFFE, 6'd10);
        cyc(0, 0, 0, 0, 1, 0, 0, 32'h0, 6'd0);

        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
